axi_lite_rd_arbiter: RTL and testbench

Sequences AXI4-Lite read transactions from several masters onto the address-decoded slave ports. Arbitrates round-robin among masters, routes the winner's address to exactly one slave port using the fixed address map below, and returns the read data to that master. One transaction is in flight at a time. Sits between the master-side read channels and the slave-side read channels of the interconnect.

---
 rtl/axi_lite_rd_arbiter.sv | 152 +++++++++++++++
 tb/tb_axi_lite_rd_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rd_arbiter.sv
// Round-robin AXI4-Lite read arbiter: N masters onto address-decoded slave ports, one read in flight.
// Optional AXI_RD_DECERR_EN: addresses >= 0x2000_0000 get a DECERR response without a slave access.
module axi_lite_rd_arbiter #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_MASTER_NUM = 2,
    parameter int unsigned AXI_PORT_NUM   = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [AXI_MASTER_NUM*AXI_ADDR_WIDTH-1:0] s_araddr_i,
    input  logic [AXI_MASTER_NUM-1:0]                s_arvalid_i,
    output logic [AXI_MASTER_NUM-1:0]                s_arready_o,
    output logic [AXI_DATA_WIDTH-1:0]                s_rdata_o,
    output logic [1:0]                               s_rresp_o,
    output logic [AXI_MASTER_NUM-1:0]                s_rvalid_o,
    input  logic [AXI_MASTER_NUM-1:0]                s_rready_i,
    output logic [AXI_ADDR_WIDTH-1:0]                m_araddr_o,
    output logic [AXI_PORT_NUM-1:0]                  m_arvalid_o,
    input  logic [AXI_PORT_NUM-1:0]                  m_arready_i,
    input  logic [AXI_PORT_NUM*AXI_DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [AXI_PORT_NUM*2-1:0]                m_rresp_i,
    input  logic [AXI_PORT_NUM-1:0]                  m_rvalid_i,
    output logic [AXI_PORT_NUM-1:0]                  m_rready_o
);

    localparam int unsigned GW = (AXI_MASTER_NUM > 1) ? $clog2(AXI_MASTER_NUM) : 1;
    localparam int unsigned PW = (AXI_PORT_NUM > 1) ? $clog2(AXI_PORT_NUM) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] Port1Base = AXI_ADDR_WIDTH'(32'h1000_0000);
`ifdef AXI_RD_DECERR_EN
    localparam logic [AXI_ADDR_WIDTH-1:0] ErrBase = AXI_ADDR_WIDTH'(32'h2000_0000);
`endif

    typedef enum logic [1:0] {StIdle, StAddr, StData, StErr} state_e;

    state_e                    state_q, state_d;
    logic [GW-1:0]             last_grant_q, last_grant_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PW-1:0]             tgt_q, tgt_d;

    logic                      found;
    logic [GW-1:0]             winner;
    logic [GW-1:0]             cand;
    logic [AXI_ADDR_WIDTH-1:0] win_addr;
    logic [PW-1:0]             dec_port;
    logic                      dec_err;
    logic [AXI_DATA_WIDTH-1:0] sel_rdata;
    logic [1:0]                sel_rresp;

    // Walk the masters starting just after the last one served; first requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = last_grant_q;
        for (int i = 0; i < AXI_MASTER_NUM; i++) begin
            cand = (cand == GW'(AXI_MASTER_NUM - 1)) ? '0 : cand + 1'b1;
            if (!found && s_arvalid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_addr = s_araddr_i[int'(winner)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        dec_err  = 1'b0;
        dec_port = '0;
        if (win_addr >= Port1Base) begin
            dec_port = PW'(1);
        end
`ifdef AXI_RD_DECERR_EN
        if (win_addr >= ErrBase) begin
            dec_err = 1'b1;
        end
`endif
    end

    assign sel_rdata  = m_rdata_i[int'(tgt_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign sel_rresp  = m_rresp_i[int'(tgt_q)*2 +: 2];
    assign m_araddr_o = addr_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        tgt_d        = tgt_q;
        s_arready_o  = '0;
        s_rvalid_o   = '0;
        s_rdata_o    = '0;
        s_rresp_o    = '0;
        m_arvalid_o  = '0;
        m_rready_o   = '0;
        case (state_q)
            StIdle: begin
                // No acceptance while in reset, so no handshake is silently dropped.
                if (found && !rst_i) begin
                    s_arready_o[winner] = 1'b1;
                    grant_d             = winner;
                    addr_d              = win_addr;
                    tgt_d               = dec_port;
                    state_d             = dec_err ? StErr : StAddr;
                end
            end
            StAddr: begin
                m_arvalid_o[tgt_q] = 1'b1;
                if (m_arready_i[tgt_q]) begin
                    state_d = StData;
                end
            end
            StData: begin
                s_rvalid_o[grant_q] = m_rvalid_i[tgt_q];
                m_rready_o[tgt_q]   = s_rready_i[grant_q];
                if (m_rvalid_i[tgt_q]) begin
                    s_rdata_o = sel_rdata;
                    s_rresp_o = sel_rresp;
                    if (s_rready_i[grant_q]) begin
                        last_grant_d = grant_q;
                        state_d      = StIdle;
                    end
                end
            end
            StErr: begin
                s_rvalid_o[grant_q] = 1'b1;
                s_rresp_o           = 2'b11;
                if (s_rready_i[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= GW'(AXI_MASTER_NUM - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            tgt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            tgt_q        <= tgt_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Bench for axi_lite_rd_arbiter: directed plan steps plus randomized reads against a transaction model.
module tb_axi_lite_rd_arbiter;

    localparam int NM = 2;
    localparam int NP = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [63:0]   s_araddr_i;
    logic [1:0]    s_arvalid_i;
    logic [1:0]    s_arready_o;
    logic [31:0]   s_rdata_o;
    logic [1:0]    s_rresp_o;
    logic [1:0]    s_rvalid_o;
    logic [1:0]    s_rready_i;
    logic [31:0]   m_araddr_o;
    logic [1:0]    m_arvalid_o;
    logic [1:0]    m_arready_i;
    logic [63:0]   m_rdata_i;
    logic [3:0]    m_rresp_i;
    logic [1:0]    m_rvalid_i;
    logic [1:0]    m_rready_o;

    axi_lite_rd_arbiter #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_MASTER_NUM(NM),
        .AXI_PORT_NUM  (NP)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_araddr_i (s_araddr_i),
        .s_arvalid_i(s_arvalid_i),
        .s_arready_o(s_arready_o),
        .s_rdata_o  (s_rdata_o),
        .s_rresp_o  (s_rresp_o),
        .s_rvalid_o (s_rvalid_o),
        .s_rready_i (s_rready_i),
        .m_araddr_o (m_araddr_o),
        .m_arvalid_o(m_arvalid_o),
        .m_arready_i(m_arready_i),
        .m_rdata_i  (m_rdata_i),
        .m_rresp_i  (m_rresp_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rready_o (m_rready_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          lg;        // model: last master served
    logic [31:0] lat_addr;  // model: address the arbiter is holding

    function automatic logic [1:0] oh(input int k);
        logic [1:0] v;
        v    = 2'b00;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input logic [1:0] req);
        for (int i = 0; i < NM; i++) begin
            if (req[(lg + 1 + i) % NM]) return (lg + 1 + i) % NM;
        end
        return -1;
    endfunction

    // -1 means DECERR
    function automatic int port_of(input logic [31:0] a);
        if (a < 32'h1000_0000) return 0;
`ifdef AXI_RD_DECERR_EN
        if (a < 32'h2000_0000) return 1;
        return -1;
`else
        return 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string ph, input logic [1:0] arready, input logic [1:0] arvalid,
                            input logic [1:0] rvalid, input logic [31:0] rdata,
                            input logic [1:0] rresp, input logic [1:0] rready);
        chk({ph, ".s_arready"}, s_arready_o, arready);
        chk({ph, ".m_arvalid"}, m_arvalid_o, arvalid);
        chk({ph, ".m_araddr"},  m_araddr_o,  lat_addr);
        chk({ph, ".s_rvalid"},  s_rvalid_o,  rvalid);
        chk({ph, ".s_rdata"},   s_rdata_o,   rdata);
        chk({ph, ".s_rresp"},   s_rresp_o,   rresp);
        chk({ph, ".m_rready"},  m_rready_o,  rready);
    endtask

    task automatic quiet_slaves();
        m_arready_i = '0;
        m_rvalid_i  = '0;
        s_rready_i  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i       = 1'b1;
        s_arvalid_i = '0;
        quiet_slaves();
        @(negedge clk_i);
        lat_addr = '0;
        lg       = NM - 1;
        #1;
        chk_outs("reset", 2'b00, 2'b00, 2'b00, 32'h0, 2'b00, 2'b00);
        rst_i = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        s_arvalid_i = '0;
        quiet_slaves();
        #1;
        chk_outs("idle0", 2'b00, 2'b00, 2'b00, 32'h0, 2'b00, 2'b00);
    endtask

    // One read; requesters in req stay valid for its whole duration.
    task automatic run_txn(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                           input int ar_wait, input int r_wait, input int rr_wait,
                           input logic [31:0] data, input logic [1:0] resp);
        int          w;
        int          p;
        logic [31:0] a;
        logic [1:0]  rr;
        @(negedge clk_i);
        s_arvalid_i = req;
        s_araddr_i  = {a1, a0};
        quiet_slaves();
        w = pick(req);
        a = (w == 0) ? a0 : a1;
        p = port_of(a);
        #1;
        chk_outs("grant", oh(w), 2'b00, 2'b00, 32'h0, 2'b00, 2'b00);
        lat_addr = a;
        if (p < 0) begin
            for (int c = 0; c <= rr_wait; c++) begin
                @(negedge clk_i);
                rr          = 2'($urandom_range(0, 3));
                rr[w]       = (c == rr_wait);
                s_rready_i  = rr;
                #1;
                chk_outs("err", 2'b00, 2'b00, oh(w), 32'h0, 2'b11, 2'b00);
            end
        end else begin
            m_rdata_i            = {~data, ~data};
            m_rdata_i[p*32 +: 32] = data;
            m_rresp_i            = {~resp, ~resp};
            m_rresp_i[p*2 +: 2]  = resp;
            for (int c = 0; c <= ar_wait; c++) begin
                @(negedge clk_i);
                m_arready_i = (c == ar_wait) ? oh(p) : 2'b00;
                #1;
                chk_outs("addr", 2'b00, oh(p), 2'b00, 32'h0, 2'b00, 2'b00);
            end
            for (int c = 0; c < r_wait; c++) begin
                @(negedge clk_i);
                m_arready_i = '0;
                s_rready_i  = 2'($urandom_range(0, 3));
                #1;
                chk_outs("rwait", 2'b00, 2'b00, 2'b00, 32'h0, 2'b00,
                         s_rready_i[w] ? oh(p) : 2'b00);
            end
            for (int c = 0; c <= rr_wait; c++) begin
                @(negedge clk_i);
                m_arready_i = '0;
                m_rvalid_i  = oh(p);
                rr          = 2'($urandom_range(0, 3));
                rr[w]       = (c == rr_wait);
                s_rready_i  = rr;
                #1;
                chk_outs("data", 2'b00, 2'b00, oh(w), data, resp,
                         (c == rr_wait) ? oh(p) : 2'b00);
            end
        end
        lg = w;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 32'h0FFF_FFFF));
            1:       return 32'h1000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
            2:       return 32'h2000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] bnd [4];
        rst_i       = 1'b1;
        s_araddr_i  = '0;
        s_arvalid_i = '0;
        m_rdata_i   = '0;
        m_rresp_i   = '0;
        quiet_slaves();
        lg       = NM - 1;
        lat_addr = '0;

        do_reset();

        // Master 0 zero-wait read from port 0.
        run_txn(2'b01, 32'h0000_0010, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);

        // Both masters contend for port 1: grants alternate starting at master 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 32'h1000_0004, 32'h1000_0004, 0, 0, 0, $urandom, 2'b00);
        end

        // Slave and master backpressure with the other master still requesting.
        run_txn(2'b11, 32'h1000_0040, 32'h1000_0080, 5, 0, 3, 32'h1234_5678, 2'b10);

        // Master 1 reads 0x3000_0000 (DECERR when enabled, port 1 otherwise).
        run_txn(2'b10, 32'h0, 32'h3000_0000, 0, 0, 0, 32'hCAFE_F00D, 2'b00);

        // Map boundaries.
        bnd[0] = 32'h0FFF_FFFF;
        bnd[1] = 32'h1000_0000;
        bnd[2] = 32'h1FFF_FFFF;
        bnd[3] = 32'h2000_0000;
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b01, bnd[i], 32'h0, 0, 1, 0, $urandom, 2'($urandom_range(0, 3)));
        end

        // Reset while in the address phase.
        do_reset();
        @(negedge clk_i);
        s_arvalid_i = 2'b10;
        s_araddr_i  = {32'h0000_0100, 32'h0};
        quiet_slaves();
        #1;
        chk_outs("rst.grant", oh(pick(2'b10)), 2'b00, 2'b00, 32'h0, 2'b00, 2'b00);
        lat_addr = 32'h0000_0100;
        @(negedge clk_i);
        s_arvalid_i = '0;
        rst_i       = 1'b1;
        #1;
        chk_outs("rst.addr", 2'b00, 2'b01, 2'b00, 32'h0, 2'b00, 2'b00);
        @(negedge clk_i);
        rst_i    = 1'b0;
        lat_addr = '0;
        lg       = NM - 1;
        #1;
        chk_outs("rst.after", 2'b00, 2'b00, 2'b00, 32'h0, 2'b00, 2'b00);
        run_txn(2'b11, 32'h0000_0200, 32'h1000_0200, 0, 0, 0, 32'h0BAD_CAFE, 2'b01);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            run_txn(2'($urandom_range(1, 3)), rand_addr(), rand_addr(),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom, 2'($urandom_range(0, 3)));
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
